mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares the single memory-controller port (wr_en, rd_en, 7-bit addr, 8-bit data) among NUM_REQ requesters.
- Typical requesters are the I2C slave front-end and local test/host logic.
- Picks one requester, issues exactly one memory strobe, waits out the fixed read latency, then acknowledges with read data.
- Sits between the requesters and the memory array; it is the only block that drives the memory strobes.

Parameters:
- DATAWIDTH, 8, memory data width.
- ADDRWIDTH, 7, memory address width.
- NUM_REQ, 4, number of requesters (2..8).
- RD_LATENCY, 1, cycles from the mem_rd_en cycle until mem_rdata is valid (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request, level.
- req_we  in  NUM_REQ  1 = write, 0 = read; sampled with req.
- req_addr  in  NUM_REQ*ADDRWIDTH  requester i at [i*ADDRWIDTH +: ADDRWIDTH].
- req_wdata  in  NUM_REQ*DATAWIDTH  requester i at [i*DATAWIDTH +: DATAWIDTH].
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATAWIDTH  last captured read data.
- busy  out  1  high whenever state != IDLE.
- mem_wr_en  out  1  memory write strobe, one cycle.
- mem_rd_en  out  1  memory read strobe, one cycle.
- mem_addr  out  ADDRWIDTH  memory address.
- mem_wdata  out  DATAWIDTH  memory write data.
- mem_rdata  in  DATAWIDTH  memory read data.

Behaviour:
- All state and outputs are registered. Reset is synchronous and active-high on clk.
- Reset values:
  - State = IDLE.
  - ack, rdata, busy, mem_wr_en, mem_rd_en, mem_addr, mem_wdata = 0.
  - last_gnt = NUM_REQ-1, so requester 0 has highest priority on the first arbitration.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from last_gnt+1 upward, wrapping modulo NUM_REQ.
  - Latch that requester's we, addr and wdata, and record gnt_idx. Go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr/mem_wdata from the latched values.
  - Assert mem_wr_en if we=1, otherwise mem_rd_en. Never assert both.
  - Write: go to DONE. Read: load cnt = RD_LATENCY and go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - In the cycle where mem_rdata is valid (RD_LATENCY cycles after the mem_rd_en cycle), capture it into rdata and go to DONE.
- DONE (1 cycle):
  - Pulse ack[gnt_idx]; all other ack bits stay 0.
  - Set last_gnt = gnt_idx. Go to IDLE.
- Latency, with req first seen in cycle 0:
  - Write: mem_wr_en in cycle 1, ack in cycle 2.
  - Read: mem_rd_en in cycle 1, ack in cycle 2+RD_LATENCY, with rdata valid in the same cycle as ack.
  - Minimum spacing between grants is 3 cycles (write) or 3+RD_LATENCY cycles (read).
- Strobe and output holding:
  - mem_addr/mem_wdata hold their last values outside ACCESS.
  - Strobes are 0 outside ACCESS.
  - rdata holds until the next read completes; writes do not change it.
- Request inputs:
  - req, req_we, req_addr and req_wdata are sampled only in IDLE.
  - Changes after the grant are ignored. Dropping req mid-transaction does not abort it; ack still pulses.
  - A requester that keeps req high after its ack re-enters arbitration with lowest priority.
- Fairness: with all requests held high, grants rotate 0,1,2,3,0,... Each requester waits at most NUM_REQ-1 transactions.
- Reset mid-transaction:
  - The transaction is abandoned at the reset edge; no ack is issued for it.
  - Strobes are 0 from the next cycle.
  - rdata is cleared, and last_gnt returns to NUM_REQ-1.

Test Plan:
- Write, requester 1, addr 7'h2A, data 8'hC3 → mem_wr_en=1 with mem_addr=2A and mem_wdata=C3 in cycle 1; ack=4'b0010 in cycle 2 only; busy high in cycles 1-2.
- RD_LATENCY=2: read by requester 0 at addr 7'h05, memory model returns 8'h5A → mem_rd_en in cycle 1; rdata=5A and ack=4'b0001 in cycle 4; rdata still 5A after a later write.
- req=4'b0101 asserted together right after reset → requester 0 served first, then requester 2; acks arrive in that order and never overlap.
- req=4'b1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3; mem_wr_en and mem_rd_en never both high.
- rst asserted during WAIT of a read by requester 3 → no ack; all outputs 0 the next cycle; the next arbitration starts from requester 0.
- Requester 2 drops req one cycle after its grant → its access still completes and ack[2] pulses; request-side addr/data changes during ACCESS do not affect mem_addr/mem_wdata.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and access sequencer for the shared memory port.
// It grants one requester, issues a single strobe, waits for read data,
// and then pulses that requester's ack. All outputs are registered.
module mem_access_arbiter #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDRWIDTH  = 7,
  parameter int NUM_REQ    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATAWIDTH-1:0]           rdata,
  output logic                           busy,
  output logic                           mem_wr_en,
  output logic                           mem_rd_en,
  output logic [ADDRWIDTH-1:0]           mem_addr,
  output logic [DATAWIDTH-1:0]           mem_wdata,
  input  logic [DATAWIDTH-1:0]           mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // One extra count value of headroom keeps the width at least 2 bits
  // and always able to hold RD_LATENCY itself.
  localparam int CNT_W = $clog2(RD_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Per-requester views of the flattened address/data buses.
  logic [ADDRWIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATAWIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  // State and registered outputs.
  state_t               state_q,     state_d;
  logic [IDX_W-1:0]     last_gnt_q,  last_gnt_d;
  logic [IDX_W-1:0]     gnt_idx_q,   gnt_idx_d;
  logic                 we_q,        we_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [NUM_REQ-1:0]   ack_q,       ack_d;
  logic [DATAWIDTH-1:0] rdata_q,     rdata_d;
  logic                 busy_q,      busy_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [ADDRWIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Arbitration result for the current cycle.
  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W:0]       arb_cand;

  // Round-robin search: first set req bit starting just after last_gnt, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_cand = {1'b0, last_gnt_q} + (IDX_W+1)'(k);
      if (arb_cand >= (IDX_W+1)'(NUM_REQ)) begin
        arb_cand = arb_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!arb_found && req[arb_cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that the registered values line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_idx_d   = gnt_idx_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          // The memory address/data registers double as the latched request.
          gnt_idx_d   = arb_idx;
          we_d        = req_we[arb_idx];
          mem_addr_d  = addr_arr[arb_idx];
          mem_wdata_d = wdata_arr[arb_idx];
          mem_wr_en_d = req_we[arb_idx];
          mem_rd_en_d = !req_we[arb_idx];
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (we_q) begin
          ack_d[gnt_idx_q] = 1'b1;
          state_d          = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY);
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q reaches 1 in the cycle mem_rdata is valid.
        if (cnt_q == CNT_W'(1)) begin
          rdata_d          = mem_rdata;
          ack_d[gnt_idx_q] = 1'b1;
          state_d          = DONE;
        end
      end

      DONE: begin
        last_gnt_d = gnt_idx_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register with synchronous reset; a reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q   <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
